mult_arbiter: RTL

- Shares one 8-bit signed multiplier (the `mult` instance, external to this block) between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Round-robin arbitration selects one pair per cycle, drives it to the multiplier, and registers the truncated product with the winner's ID into a single-entry result buffer with its own valid/ready handshake.
- Sits between the picoMips execute-stage clients and the shared multiplier resource.

---
 rtl/mult_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external 8-bit signed multiplier between NREQ
// requesters, with a single-entry registered result buffer (valid/ready).
module mult_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [7:0]        mul_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data,
    output logic [IDW-1:0]    res_id
);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} buf_state_t;

    buf_state_t     r_state;
    buf_state_t     w_state_next;
    logic [IDW-1:0] r_rr_ptr;
    logic [7:0]     r_res_data;
    logic [IDW-1:0] r_res_id;
    logic [IDW-1:0] w_win;
    logic           w_found;
    logic           w_can_accept;
    logic           w_accept;

    // Round-robin scan: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_can_accept = (r_state == ST_EMPTY) || res_ready;
    assign w_accept     = w_can_accept && w_found;

    // Grant and multiplier operand steering; operands follow the winner even while stalled.
    always_comb begin
        req_ready = '0;
        mul_a     = 8'd0;
        mul_b     = 8'd0;
        if (w_found) begin
            mul_a = req_a[int'(w_win)*8 +: 8];
            mul_b = req_b[int'(w_win)*8 +: 8];
            if (w_can_accept) begin
                req_ready[w_win] = 1'b1;
            end else begin
                req_ready = '0;
            end
        end else begin
            req_ready = '0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Buffer next state: accept refills, a lone drain empties, otherwise hold.
    always_comb begin
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_next = ST_FULL;
                else          w_state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (w_accept)       w_state_next = ST_FULL;
                else if (res_ready) w_state_next = ST_EMPTY;
                else                w_state_next = ST_FULL;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Buffer outputs.
    always_comb begin
        res_valid = (r_state == ST_FULL);
        res_data  = r_res_data;
        res_id    = r_res_id;
    end

    // Product capture and pointer advance; data/id hold when draining or stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_data <= 8'd0;
            r_res_id   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_accept) begin
            r_res_data <= mul_out;
            r_res_id   <= w_win;
            if (int'(w_win) == NREQ - 1) r_rr_ptr <= '0;
            else                         r_rr_ptr <= w_win + 1'b1;
        end else begin
            r_res_data <= r_res_data;
            r_res_id   <= r_res_id;
            r_rr_ptr   <= r_rr_ptr;
        end
    end

endmodule
